// File: rtl/stu_mgr_tx.sv
// stu_mgr_tx
// Stack-side transmitter for the upstream bus to one manager. Result words
// from the PE-side source are buffered in a small FIFO. Each word is tagged
// with SOM/EOM framing and the OOB data of its packet, then presented to the
// manager over a valid/ready handshake.
//
// Ports
//   clk, reset_poweron          clock, synchronous active-high reset
//   pe__stu__*                  source side: valid/ready, type, data, oob, eom
//   stu__mgr__* / mgr__stu__*   manager side: valid/ready, cntl, type, data, oob
//   stu__sys__pkt_count         packets fully sent (EOM transferred), wraps
//   stu__sys__busy              FIFO non-empty or a packet is mid-flight
//
// Output FSM
//   state   | meaning
//   IDLE    | between packets; the next head word must carry SOM
//   BODY    | SOM sent, waiting for the EOM word of the packet
module stu_mgr_tx #(
    parameter int DATA_W = 64,
    parameter int OOB_W  = 32,
    parameter int TYPE_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              pe__stu__valid,
    output logic              stu__pe__ready,
    input  logic [TYPE_W-1:0] pe__stu__type,
    input  logic [DATA_W-1:0] pe__stu__data,
    input  logic [OOB_W-1:0]  pe__stu__oob_data,
    input  logic              pe__stu__eom,
    output logic              stu__mgr__valid,
    output logic [1:0]        stu__mgr__cntl,
    input  logic              mgr__stu__ready,
    output logic [TYPE_W-1:0] stu__mgr__type,
    output logic [DATA_W-1:0] stu__mgr__data,
    output logic [OOB_W-1:0]  stu__mgr__oob_data,
    output logic [15:0]       stu__sys__pkt_count,
    output logic              stu__sys__busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    logic [TYPE_W-1:0] r_mem_type [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [OOB_W-1:0]  r_mem_oob  [DEPTH];
    logic              r_mem_eom  [DEPTH];
    logic              r_mem_som  [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_in_pkt;
    logic [OOB_W-1:0]  r_pkt_oob;
    state_t            r_state;
    logic [15:0]       r_pkt_count;

    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_som_in;
    logic [OOB_W-1:0]  w_oob_in;
    logic              w_head_som;
    logic              w_head_eom;

    // Ready looks only at the stored count (plus reset), never at the
    // manager's ready, so there is no combinational path across the block.
    assign stu__pe__ready = !reset_poweron && (r_count < DEPTH_C);

    assign w_push     = pe__stu__valid && stu__pe__ready;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && mgr__stu__ready;
    assign w_som_in   = !r_in_pkt;
    assign w_oob_in   = w_som_in ? pe__stu__oob_data : r_pkt_oob;
    assign w_head_som = r_mem_som[r_rd_ptr];
    assign w_head_eom = r_mem_eom[r_rd_ptr];

    // Outputs are zeroed when empty so stale FIFO contents never show up
    // after reset or after the FIFO drains.
    assign stu__mgr__valid     = w_valid;
    assign stu__mgr__cntl      = w_valid ? {w_head_eom, w_head_som} : 2'b00;
    assign stu__mgr__type      = w_valid ? r_mem_type[r_rd_ptr] : '0;
    assign stu__mgr__data      = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign stu__mgr__oob_data  = w_valid ? r_mem_oob[r_rd_ptr]  : '0;
    assign stu__sys__pkt_count = r_pkt_count;
    assign stu__sys__busy      = w_valid || (r_state == ST_BODY);

    // Storage is not reset; the outputs are qualified by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_type[r_wr_ptr] <= pe__stu__type;
            r_mem_data[r_wr_ptr] <= pe__stu__data;
            r_mem_oob[r_wr_ptr]  <= w_oob_in;
            r_mem_eom[r_wr_ptr]  <= pe__stu__eom;
            r_mem_som[r_wr_ptr]  <= w_som_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_pkt    <= 1'b0;
            r_pkt_oob   <= '0;
            r_state     <= ST_IDLE;
            r_pkt_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_in_pkt <= !pe__stu__eom;
                if (w_som_in) begin
                    r_pkt_oob <= pe__stu__oob_data;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                if (w_head_eom) begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                end
                case (r_state)
                    ST_IDLE: if (w_head_som && !w_head_eom) r_state <= ST_BODY;
                    ST_BODY: if (w_head_eom) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A new SOM while a packet is still open cannot be produced by the
    // input framing logic; catch it if it ever happens.
    always @(posedge clk) begin
        if (!reset_poweron && w_pop && (r_state == ST_BODY)) begin
            assert (!w_head_som);
        end
    end
`endif

endmodule

// File: tb/tb_stu_mgr_tx.sv
module tb_stu_mgr_tx;

    logic        clk;
    logic        reset_poweron;
    logic        pe__stu__valid;
    logic        stu__pe__ready;
    logic [1:0]  pe__stu__type;
    logic [63:0] pe__stu__data;
    logic [31:0] pe__stu__oob_data;
    logic        pe__stu__eom;
    logic        stu__mgr__valid;
    logic [1:0]  stu__mgr__cntl;
    logic        mgr__stu__ready;
    logic [1:0]  stu__mgr__type;
    logic [63:0] stu__mgr__data;
    logic [31:0] stu__mgr__oob_data;
    logic [15:0] stu__sys__pkt_count;
    logic        stu__sys__busy;

    int tests_run;
    int tests_failed;

    stu_mgr_tx #(.DATA_W(64), .OOB_W(32), .TYPE_W(2), .DEPTH(4)) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .pe__stu__valid      (pe__stu__valid),
        .stu__pe__ready      (stu__pe__ready),
        .pe__stu__type       (pe__stu__type),
        .pe__stu__data       (pe__stu__data),
        .pe__stu__oob_data   (pe__stu__oob_data),
        .pe__stu__eom        (pe__stu__eom),
        .stu__mgr__valid     (stu__mgr__valid),
        .stu__mgr__cntl      (stu__mgr__cntl),
        .mgr__stu__ready     (mgr__stu__ready),
        .stu__mgr__type      (stu__mgr__type),
        .stu__mgr__data      (stu__mgr__data),
        .stu__mgr__oob_data  (stu__mgr__oob_data),
        .stu__sys__pkt_count (stu__sys__pkt_count),
        .stu__sys__busy      (stu__sys__busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  t;
        logic [31:0] o;
        logic [1:0]  c;
    } exp_t;

    // Inputs change on the falling edge; DUT outputs are read 1 time unit later.
    task automatic drive_word(input logic v, input logic [1:0] t, input logic [63:0] d,
                              input logic [31:0] o, input logic e);
        pe__stu__valid    = v;
        pe__stu__type     = t;
        pe__stu__data     = d;
        pe__stu__oob_data = o;
        pe__stu__eom      = e;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_poweron   = 1'b1;
        mgr__stu__ready = 1'b0;
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_poweron = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_poweron   = 1'b1;
        mgr__stu__ready = 1'b1;
        drive_word(1'b1, 2'd3, 64'hDEAD, 32'hBEEF, 1'b1);
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        #1;
        tests_run++;
        if (stu__pe__ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 0", stu__pe__ready);
        end
        tests_run++;
        if ({stu__mgr__valid, stu__mgr__cntl, stu__mgr__type} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: valid=%b cntl=%b type=%b want 0", stu__mgr__valid, stu__mgr__cntl, stu__mgr__type);
        end
        tests_run++;
        if (stu__mgr__data !== 64'd0 || stu__mgr__oob_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: data=%h oob=%h want 0", stu__mgr__data, stu__mgr__oob_data);
        end
        tests_run++;
        if (stu__sys__pkt_count !== 16'd0 || stu__sys__busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sys: pkt=%h busy=%b want 0", stu__sys__pkt_count, stu__sys__busy);
        end
        reset_poweron = 1'b0;
        #1;
        tests_run++;
        if (stu__pe__ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_ready: got %b want 1", stu__pe__ready);
        end
    endtask

    task automatic test_single;
        do_reset();
        mgr__stu__ready = 1'b1;
        drive_word(1'b1, 2'd2, 64'hA5A5, 32'h11, 1'b1);
        #1;
        tests_run++;
        if (stu__pe__ready !== 1'b1 || stu__mgr__valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_push: ready=%b valid=%b want 1 0", stu__pe__ready, stu__mgr__valid);
        end
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        #1;
        tests_run++;
        if (stu__mgr__valid !== 1'b1 || stu__mgr__cntl !== 2'b11 || stu__mgr__type !== 2'd2 ||
            stu__mgr__data !== 64'hA5A5 || stu__mgr__oob_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL single_out: valid=%b cntl=%b type=%0d data=%h oob=%h want 1 11 2 a5a5 11",
                     stu__mgr__valid, stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__mgr__valid !== 1'b0 || stu__sys__pkt_count !== 16'd1 || stu__sys__busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: valid=%b pkt=%0d busy=%b want 0 1 0",
                     stu__mgr__valid, stu__sys__pkt_count, stu__sys__busy);
        end
    endtask

    task automatic test_three_word;
        logic [1:0]  types [3];
        logic [63:0] datas [3];
        logic [31:0] oobs  [3];
        logic [1:0]  cntls [3];
        types = '{2'd1, 2'd2, 2'd3};
        datas = '{64'h1111, 64'h2222, 64'h3333};
        oobs  = '{32'h22, 32'h99, 32'h99};
        cntls = '{2'b01, 2'b00, 2'b10};
        do_reset();
        mgr__stu__ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 3) drive_word(1'b1, types[i], datas[i], oobs[i], i == 2);
            else       drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
            #1;
            if (i > 0) begin
                tests_run++;
                if (stu__mgr__valid !== 1'b1 || stu__mgr__cntl !== cntls[i-1] ||
                    stu__mgr__type !== types[i-1] || stu__mgr__data !== datas[i-1] ||
                    stu__mgr__oob_data !== 32'h22 || stu__sys__busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL three_word_%0d: valid=%b cntl=%b data=%h oob=%h busy=%b want 1 %b %h 22 1",
                             i - 1, stu__mgr__valid, stu__mgr__cntl, stu__mgr__data,
                             stu__mgr__oob_data, stu__sys__busy, cntls[i-1], datas[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__sys__pkt_count !== 16'd1 || stu__mgr__valid !== 1'b0 || stu__sys__busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL three_word_done: pkt=%0d valid=%b busy=%b want 1 0 0",
                     stu__sys__pkt_count, stu__mgr__valid, stu__sys__busy);
        end
    endtask

    task automatic test_full_hold;
        int k;
        int r;
        logic [1:0] ec;
        do_reset();
        k = 0;
        r = 0;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            drive_word(1'b1, 2'd1, 64'h100 + 64'(k), 32'h40 + 32'(k), k == 5);
            #1;
            if (stu__pe__ready) k++;
        end
        @(negedge clk);
        drive_word(1'b1, 2'd1, 64'h104, 32'h44, 1'b0);
        #1;
        tests_run++;
        if (k !== 4 || stu__pe__ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready: pushes=%0d ready=%b want 4 0", k, stu__pe__ready);
        end
        for (int h = 0; h < 3; h++) begin
            if (h > 0) begin @(negedge clk); #1; end
            tests_run++;
            if (stu__mgr__valid !== 1'b1 || stu__mgr__data !== 64'h100 ||
                stu__mgr__cntl !== 2'b01 || stu__mgr__oob_data !== 32'h40) begin
                tests_failed++;
                $display("FAIL full_hold_%0d: valid=%b data=%h cntl=%b oob=%h want 1 100 01 40",
                         h, stu__mgr__valid, stu__mgr__data, stu__mgr__cntl, stu__mgr__oob_data);
            end
        end
        @(negedge clk);
        mgr__stu__ready = 1'b1;
        for (int cyc = 0; cyc < 40 && r < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (k < 6) drive_word(1'b1, 2'd1, 64'h100 + 64'(k), 32'h40 + 32'(k), k == 5);
            else       drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
            #1;
            if (cyc == 0) begin
                tests_run++;
                if (stu__pe__ready !== 1'b0) begin
                    tests_failed++; $display("FAIL full_pop_ready: got %b want 0", stu__pe__ready);
                end
            end
            if (pe__stu__valid && stu__pe__ready) k++;
            if (stu__mgr__valid && mgr__stu__ready) begin
                ec = (r == 0) ? 2'b01 : (r == 5) ? 2'b10 : 2'b00;
                tests_run++;
                if (stu__mgr__data !== 64'h100 + 64'(r) || stu__mgr__cntl !== ec ||
                    stu__mgr__oob_data !== 32'h40) begin
                    tests_failed++;
                    $display("FAIL drain_%0d: data=%h cntl=%b oob=%h want %h %b 40", r,
                             stu__mgr__data, stu__mgr__cntl, stu__mgr__oob_data, 64'h100 + 64'(r), ec);
                end
                r++;
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (r !== 6 || stu__mgr__valid !== 1'b0 || stu__sys__pkt_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL drain_done: popped=%0d valid=%b pkt=%0d want 6 0 1", r, stu__mgr__valid, stu__sys__pkt_count);
        end
    endtask

    task automatic test_random;
        exp_t        q[$];
        exp_t        e;
        exp_t        head;
        int          pkts_sent;
        int          pkts_rcv;
        int          idx;
        int          len;
        int          cyc;
        logic        have;
        logic [31:0] pkt_oob;
        logic [63:0] wd;
        logic [1:0]  wt;
        logic [31:0] wo;
        logic        we;
        logic        stall;
        logic [101:0] prev;
        int          word_errs;
        int          hold_errs;
        do_reset();
        pkts_sent = 0; pkts_rcv = 0; idx = 0; len = 1; cyc = 0;
        have = 1'b0; stall = 1'b0; prev = '0; pkt_oob = '0;
        wd = '0; wt = '0; wo = '0; we = 1'b0;
        word_errs = 0; hold_errs = 0;
        while (pkts_rcv < 1000 && cyc < 40000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (!have && pkts_sent < 1000) begin
                if (idx == 0) begin
                    len = $urandom_range(1, 8);
                    pkt_oob = $urandom;
                end
                wd = {$urandom, $urandom};
                wt = 2'($urandom_range(0, 3));
                wo = (idx == 0) ? pkt_oob : $urandom;
                we = (idx == len - 1);
                have = 1'b1;
            end
            drive_word(have && ($urandom_range(0, 4) != 0), wt, wd, wo, we);
            mgr__stu__ready = ($urandom_range(0, 4) != 0);
            #1;
            if (stall) begin
                tests_run++;
                if ({stu__mgr__valid, stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data} !== prev) begin
                    tests_failed++;
                    if (hold_errs < 5)
                        $display("FAIL rand_hold: outputs changed while stalled, data=%h prev=%h",
                                 stu__mgr__data, prev[95:32]);
                    hold_errs++;
                end
            end
            stall = stu__mgr__valid && !mgr__stu__ready;
            prev  = {stu__mgr__valid, stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data};
            if (pe__stu__valid && stu__pe__ready) begin
                e.d = wd; e.t = wt; e.o = pkt_oob; e.c = {we, idx == 0};
                q.push_back(e);
                have = 1'b0;
                if (we) begin idx = 0; pkts_sent++; end
                else idx++;
            end
            if (stu__mgr__valid && mgr__stu__ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_word: unexpected word data=%h", stu__mgr__data);
                end else begin
                    head = q.pop_front();
                    if (stu__mgr__data !== head.d || stu__mgr__type !== head.t ||
                        stu__mgr__oob_data !== head.o || stu__mgr__cntl !== head.c) begin
                        tests_failed++;
                        if (word_errs < 5)
                            $display("FAIL rand_word: data=%h type=%0d oob=%h cntl=%b want %h %0d %h %b",
                                     stu__mgr__data, stu__mgr__type, stu__mgr__oob_data, stu__mgr__cntl,
                                     head.d, head.t, head.o, head.c);
                        word_errs++;
                    end
                    if (head.c[1]) pkts_rcv++;
                end
            end
        end
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        #1;
        tests_run++;
        if (pkts_rcv !== 1000 || q.size() !== 0 || stu__sys__pkt_count !== 16'd1000) begin
            tests_failed++;
            $display("FAIL rand_done: rcv=%0d left=%0d pkt=%0d want 1000 0 1000",
                     pkts_rcv, q.size(), stu__sys__pkt_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        mgr__stu__ready = 1'b1;
        drive_word(1'b1, 2'd0, 64'h77, 32'h7, 1'b1);
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__sys__pkt_count !== 16'd1) begin
            tests_failed++; $display("FAIL rmid_pre: pkt=%0d want 1", stu__sys__pkt_count);
        end
        @(negedge clk);
        mgr__stu__ready = 1'b0;
        drive_word(1'b1, 2'd1, 64'hA0, 32'h55, 1'b0);
        @(negedge clk);
        drive_word(1'b1, 2'd1, 64'hA1, 32'h56, 1'b0);
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        reset_poweron = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__mgr__valid !== 1'b0 || stu__mgr__cntl !== 2'b00 || stu__mgr__data !== 64'd0 ||
            stu__mgr__oob_data !== 32'd0 || stu__mgr__type !== 2'd0 || stu__sys__pkt_count !== 16'd0 ||
            stu__sys__busy !== 1'b0 || stu__pe__ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_reset: valid=%b cntl=%b data=%h oob=%h pkt=%0d busy=%b ready=%b want all 0",
                     stu__mgr__valid, stu__mgr__cntl, stu__mgr__data, stu__mgr__oob_data,
                     stu__sys__pkt_count, stu__sys__busy, stu__pe__ready);
        end
        reset_poweron = 1'b0;
        @(negedge clk);
        mgr__stu__ready = 1'b1;
        drive_word(1'b1, 2'd2, 64'hC0, 32'h33, 1'b0);
        #1;
        tests_run++;
        if (stu__pe__ready !== 1'b1 || stu__mgr__valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_flushed: ready=%b valid=%b want 1 0", stu__pe__ready, stu__mgr__valid);
        end
        @(negedge clk);
        drive_word(1'b1, 2'd2, 64'hC1, 32'h44, 1'b1);
        #1;
        tests_run++;
        if (stu__mgr__cntl !== 2'b01 || stu__mgr__data !== 64'hC0 || stu__mgr__oob_data !== 32'h33) begin
            tests_failed++;
            $display("FAIL rmid_som: cntl=%b data=%h oob=%h want 01 c0 33",
                     stu__mgr__cntl, stu__mgr__data, stu__mgr__oob_data);
        end
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        #1;
        tests_run++;
        if (stu__mgr__cntl !== 2'b10 || stu__mgr__data !== 64'hC1 || stu__mgr__oob_data !== 32'h33) begin
            tests_failed++;
            $display("FAIL rmid_eom: cntl=%b data=%h oob=%h want 10 c1 33",
                     stu__mgr__cntl, stu__mgr__data, stu__mgr__oob_data);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__sys__pkt_count !== 16'd1 || stu__sys__busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_done: pkt=%0d busy=%b want 1 0", stu__sys__pkt_count, stu__sys__busy);
        end
    endtask

    task automatic test_wrap;
        int n;
        int cyc;
        do_reset();
        mgr__stu__ready = 1'b1;
        drive_word(1'b1, 2'd0, 64'h5, 32'h5, 1'b1);
        n = 0;
        cyc = 0;
        while (n < 65535 && cyc < 70000) begin
            #1;
            if (stu__pe__ready) n++;
            cyc++;
            if (n < 65535) @(negedge clk);
        end
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (n !== 65535 || stu__sys__pkt_count !== 16'hFFFF || stu__mgr__valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_preload: pushes=%0d pkt=%h valid=%b want 65535 ffff 0",
                     n, stu__sys__pkt_count, stu__mgr__valid);
        end
        @(negedge clk);
        drive_word(1'b1, 2'd0, 64'h6, 32'h6, 1'b1);
        @(negedge clk);
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        tests_run++;
        if (stu__sys__pkt_count !== 16'h0000) begin
            tests_failed++; $display("FAIL wrap_rollover: pkt=%h want 0000", stu__sys__pkt_count);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset_poweron   = 1'b1;
        mgr__stu__ready = 1'b0;
        drive_word(1'b0, 2'd0, 64'd0, 32'd0, 1'b0);
        test_reset();
        test_single();
        test_three_word();
        test_full_hold();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
